// File: rtl/bram_dp_init.sv
// bram_dp_init: dual-port block RAM (port A read/write, port B read-only)
// with registered 1-cycle reads and a built-in init engine that sweeps
// INIT_VAL into every word after reset or on a CLEAR request.
module bram_dp_init #(
    parameter int unsigned     DW        = 18,
    parameter int unsigned     AW        = 12,
    parameter int unsigned     DEPTH     = 2**AW,
    parameter logic [DW-1:0]   INIT_VAL  = '0,
    parameter int unsigned     ZERO_IDLE = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLEAR,
    output logic          READY,
    input  logic          A_EN,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_DIN,
    output logic [DW-1:0] A_DOUT,
    output logic          A_VALID,
    input  logic          B_EN,
    input  logic [AW-1:0] B_ADDR,
    output logic [DW-1:0] B_DOUT,
    output logic          B_VALID
);

    localparam int unsigned    IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t          state;
    logic [IW-1:0]   cnt;
    logic [DW-1:0]   mem [0:DEPTH-1];

    logic            a_in, b_in;
    logic            a_wr, a_rd, b_rd, bypass;
    logic [IW-1:0]   a_idx, b_idx;

    assign READY = (state == S_RUN);

    // Request qualification: everything is dropped until the sweep is done.
    always_comb begin
        a_in   = (32'(A_ADDR) < DEPTH);
        b_in   = (32'(B_ADDR) < DEPTH);
        a_idx  = A_ADDR[IW-1:0];
        b_idx  = B_ADDR[IW-1:0];
        a_wr   = READY && A_EN && A_WE && a_in;
        a_rd   = READY && A_EN && !A_WE;
        b_rd   = READY && B_EN;
        bypass = a_wr && (A_ADDR == B_ADDR);
    end

    // Init engine: one word per cycle, CLEAR only honoured once running.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == LAST) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (CLEAR) begin
                        state <= S_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep and port A; the array has no reset.
    always_ff @(posedge CLK) begin
        if (state == S_INIT) begin
            mem[cnt] <= INIT_VAL;
        end else if (a_wr) begin
            mem[a_idx] <= A_DIN;
        end
    end

    // Port A read register; out-of-range reads return INIT_VAL.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            A_VALID <= 1'b0;
            A_DOUT  <= '0;
        end else begin
            A_VALID <= a_rd;
            if (a_rd) begin
                A_DOUT <= a_in ? mem[a_idx] : INIT_VAL;
            end else if (ZERO_IDLE != 0) begin
                A_DOUT <= '0;
            end
        end
    end

    // Port B read register with write-first bypass from a same-address A write.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            B_VALID <= 1'b0;
            B_DOUT  <= '0;
        end else begin
            B_VALID <= b_rd;
            if (b_rd) begin
                if (!b_in) begin
                    B_DOUT <= INIT_VAL;
                end else if (bypass) begin
                    B_DOUT <= A_DIN;
                end else begin
                    B_DOUT <= mem[b_idx];
                end
            end else if (ZERO_IDLE != 0) begin
                B_DOUT <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_dp_init.sv
// tb_bram_dp_init: scoreboard bench for bram_dp_init. Two instances share
// stimulus, one with ZERO_IDLE=1 and one with ZERO_IDLE=0.
module tb_bram_dp_init;

    localparam int unsigned   DW    = 18;
    localparam int unsigned   AW    = 5;
    localparam int unsigned   DEPTH = 16;
    localparam logic [DW-1:0] IV    = 18'h3FFFF;

    logic          CLK    = 1'b0;
    logic          RST    = 1'b0;
    logic          CLEAR  = 1'b0;
    logic          A_EN   = 1'b0;
    logic          A_WE   = 1'b0;
    logic [AW-1:0] A_ADDR = '0;
    logic [DW-1:0] A_DIN  = '0;
    logic          B_EN   = 1'b0;
    logic [AW-1:0] B_ADDR = '0;

    logic          rdy_z, av_z, bv_z, rdy_h, av_h, bv_h;
    logic [DW-1:0] ad_z, bd_z, ad_h, bd_h;

    bram_dp_init #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .INIT_VAL(IV), .ZERO_IDLE(1)) dut_z (
        .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .READY(rdy_z),
        .A_EN(A_EN), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
        .A_DOUT(ad_z), .A_VALID(av_z),
        .B_EN(B_EN), .B_ADDR(B_ADDR), .B_DOUT(bd_z), .B_VALID(bv_z)
    );

    bram_dp_init #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .INIT_VAL(IV), .ZERO_IDLE(0)) dut_h (
        .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .READY(rdy_h),
        .A_EN(A_EN), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
        .A_DOUT(ad_h), .A_VALID(av_h),
        .B_EN(B_EN), .B_ADDR(B_ADDR), .B_DOUT(bd_h), .B_VALID(bv_h)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          rdy;
        logic          av;
        logic          bv;
        logic [DW-1:0] ad_z;
        logic [DW-1:0] ad_h;
        logic [DW-1:0] bd_z;
        logic [DW-1:0] bd_h;
    } exp_t;

    exp_t          sbq[$];
    int unsigned   n_chk  = 0;
    int unsigned   n_pass = 0;

    // Reference model state
    logic [DW-1:0] mm [16];
    bit            m_ready = 1'b0;
    logic [3:0]    m_cnt   = '0;
    logic [DW-1:0] la_h    = '0;
    logic [DW-1:0] lb_h    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, push the model's prediction, then compare after the edge.
    task automatic cycle(input bit a_en, input bit a_we, input logic [AW-1:0] a_addr,
                         input logic [DW-1:0] a_din, input bit b_en,
                         input logic [AW-1:0] b_addr, input bit clr);
        exp_t          e, o;
        logic [DW-1:0] v;
        bit            wr;
        A_EN = a_en; A_WE = a_we; A_ADDR = a_addr; A_DIN = a_din;
        B_EN = b_en; B_ADDR = b_addr; CLEAR = clr;

        wr   = m_ready && a_en && a_we && (32'(a_addr) < DEPTH);
        e.av = m_ready && a_en && !a_we;
        if (e.av) begin
            v = (32'(a_addr) < DEPTH) ? mm[a_addr[3:0]] : IV;
            e.ad_z = v;
            la_h   = v;
        end else begin
            e.ad_z = '0;
        end
        e.ad_h = la_h;
        e.bv = m_ready && b_en;
        if (e.bv) begin
            if (32'(b_addr) >= DEPTH)    v = IV;
            else if (wr && a_addr == b_addr) v = a_din;
            else                         v = mm[b_addr[3:0]];
            e.bd_z = v;
            lb_h   = v;
        end else begin
            e.bd_z = '0;
        end
        e.bd_h = lb_h;

        if (m_ready) begin
            if (wr) mm[a_addr[3:0]] = a_din;
            if (clr) begin
                m_ready = 1'b0;
                m_cnt   = '0;
            end
        end else begin
            mm[m_cnt] = IV;
            if (m_cnt == 4'd15) m_ready = 1'b1;
            else                m_cnt   = m_cnt + 4'd1;
        end
        e.rdy = m_ready;
        sbq.push_back(e);

        @(posedge CLK);
        @(negedge CLK);
        if (sbq.size() == 0) begin
            check("scoreboard empty", 32'd0, 32'd1);
        end else begin
            o = sbq.pop_front();
            check("READY z",   32'(rdy_z), 32'(o.rdy));
            check("READY h",   32'(rdy_h), 32'(o.rdy));
            check("A_VALID z", 32'(av_z),  32'(o.av));
            check("A_VALID h", 32'(av_h),  32'(o.av));
            check("B_VALID z", 32'(bv_z),  32'(o.bv));
            check("B_VALID h", 32'(bv_h),  32'(o.bv));
            check("A_DOUT z",  32'(ad_z),  32'(o.ad_z));
            check("A_DOUT h",  32'(ad_h),  32'(o.ad_h));
            check("B_DOUT z",  32'(bd_z),  32'(o.bd_z));
            check("B_DOUT h",  32'(bd_h),  32'(o.bd_h));
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " READY"}, 32'({rdy_z, rdy_h}), 32'd0);
        check({tag, " VALID"}, 32'({av_z, bv_z, av_h, bv_h}), 32'd0);
        check({tag, " DOUT z"}, 32'(ad_z | bd_z), 32'd0);
        check({tag, " DOUT h"}, 32'(ad_h | bd_h), 32'd0);
    endtask

    // Assert RST away from the clock edge, confirm the immediate effect, release on a negedge.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b0;
        A_EN = 0; A_WE = 0; B_EN = 0; CLEAR = 0;
        #1;
        check_reset_outputs(tag);
        m_ready = 1'b0; m_cnt = '0; la_h = '0; lb_h = '0;
        sbq.delete();
        @(negedge CLK);
        @(negedge CLK);
        check_reset_outputs({tag, " held"});
        RST = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mm[i] = '0;

        // Power-on reset
        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b1;

        // Sweep: requests and CLEAR mid-sweep are ignored, READY after exactly DEPTH cycles
        idle(7);
        cycle(1, 1, 5'd4, 18'h00111, 1, 5'd4, 1);
        cycle(1, 0, 5'd4, '0, 1, 5'd9, 0);
        idle(7);

        // Every word holds INIT_VAL, reads back-to-back on both ports
        for (int unsigned i = 0; i < DEPTH; i++)
            cycle(1, 0, 5'(i), '0, 1, 5'(DEPTH - 1 - i), 0);

        // Basic write on A, read on B next cycle
        cycle(1, 1, 5'd7, 18'h12345, 0, '0, 0);
        cycle(0, 0, '0, '0, 1, 5'd7, 0);

        // Write-first bypass, then confirm the stored value
        cycle(1, 1, 5'd3, 18'h00ABC, 1, 5'd3, 0);
        cycle(1, 0, 5'd3, '0, 1, 5'd7, 0);

        // Hold vs zero-idle behaviour
        cycle(1, 1, 5'd2, 18'h00055, 0, '0, 0);
        cycle(1, 0, 5'd2, '0, 1, 5'd2, 0);
        idle(3);

        // Out-of-range: write dropped, reads give INIT_VAL
        cycle(1, 1, 5'd16, 18'h0F0F0, 0, '0, 0);
        cycle(1, 0, 5'd16, '0, 1, 5'd31, 0);
        cycle(1, 0, 5'd0, '0, 1, 5'd16, 0);

        // Clear: write in the CLEAR cycle is performed then swept, read in it completes
        cycle(1, 1, 5'd5, 18'h00001, 0, '0, 0);
        cycle(1, 0, 5'd5, '0, 0, '0, 0);
        cycle(1, 1, 5'd6, 18'h00777, 1, 5'd5, 1);
        for (int unsigned i = 0; i < DEPTH - 1; i++)
            cycle(1, i[0], 5'(i), 18'h2AAAA, 1, 5'(i), 0);
        cycle(1, 0, 5'd5, '0, 1, 5'd6, 0);
        cycle(1, 0, 5'd7, '0, 1, 5'd3, 0);

        // Reset mid-read: held data on the ZERO_IDLE=0 instance drops to 0 at once
        cycle(1, 1, 5'd2, 18'h00055, 0, '0, 0);
        cycle(1, 0, 5'd2, '0, 1, 5'd2, 0);
        async_reset("rst mid-read");
        idle(DEPTH);

        // Reset at cycle 5 of a CLEAR-started sweep, full sweep runs again
        cycle(1, 1, 5'd9, 18'h3C3C3, 0, '0, 0);
        cycle(0, 0, '0, '0, 0, '0, 1);
        idle(5);
        async_reset("rst mid-sweep");
        idle(DEPTH);
        cycle(1, 0, 5'd9, '0, 1, 5'd15, 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_dp_init.md
# bram_dp_init

Parametrised dual-port block RAM for the BCP datapath: one read/write port (A) and one read-only port (B) over a single shared array, with registered 1-cycle reads. Replaces the bulk synchronous array clear with a built-in init engine that sweeps the array one word per cycle after reset or on a CLEAR request. The engine signals its completion with READY. Clause and assignment stores instantiate it at their own width and depth.

## Interface
- DW, 18: data width in bits.
- AW, 12: address width in bits.
- DEPTH, 2**AW: number of words; legal range 2..2**AW.
- INIT_VAL, 0 (DW bits): value the init engine writes to every word.
- ZERO_IDLE, 1: 1 = each DOUT drives 0 in any cycle where its VALID is 0; 0 = each DOUT holds its last read value.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- CLEAR  in  1  single-cycle pulse that re-runs the init sweep; honoured only while READY=1.
- READY  out  1  1 = array initialised and both ports accept requests.
- A_EN  in  1  port A request.
- A_WE  in  1  port A operation: 1 = write, 0 = read.
- A_ADDR  in  AW  port A address.
- A_DIN  in  DW  port A write data.
- A_DOUT  out  DW  port A read data, registered.
- A_VALID  out  1  A_DOUT holds the result of the previous cycle's read.
- B_EN  in  1  port B read request.
- B_ADDR  in  AW  port B address.
- B_DOUT  out  DW  port B read data, registered.
- B_VALID  out  1  B_DOUT holds the result of the previous cycle's read.

## Operation
- FSM, two states:
  - INIT: the address counter writes INIT_VAL to word cnt, then increments. When cnt = DEPTH-1, the FSM moves to RUN.
  - RUN: READY=1. CLEAR=1 moves the FSM to INIT with cnt=0.
- RST low → FSM=INIT, cnt=0. The array itself is not reset; its contents are undefined until the sweep completes.
- While READY=0: all A/B requests are dropped (no write, VALID=0). CLEAR is ignored; a sweep is never restarted mid-way except by RST.
- Port A write: A_EN & A_WE & READY → mem[A_ADDR] ← A_DIN at the edge. A_VALID stays 0.
- Port A read: A_EN & !A_WE & READY → A_DOUT = mem[A_ADDR] after the edge, A_VALID=1 for one cycle.
- Port B read: same behaviour as a port A read, independent of port A.
- Same-cycle A write and B read to the same address: B returns A_DIN (write-first bypass).
- Address ≥ DEPTH: a write is dropped; a read returns INIT_VAL with VALID=1.
- CLEAR in the same cycle as an A write (READY=1): the write is performed, then INIT begins. The sweep overwrites it.
- A read issued in the same cycle as CLEAR completes normally, with VALID=1 next cycle.
- ZERO_IDLE=1: DOUT=0 whenever VALID=0. ZERO_IDLE=0: DOUT holds its value; only a new read changes it.

## Timing
- During RST low: READY=0, A_DOUT=B_DOUT=0, A_VALID=B_VALID=0, cnt=0.
- Init length: word 0 is written at the first rising edge after RST rises. Word DEPTH-1 is written at edge DEPTH. READY=1 from edge DEPTH onwards, i.e. after exactly DEPTH cycles.
- CLEAR sampled at edge k → READY=0 from edge k. READY=1 again from edge k+DEPTH.
- Read latency: 1 cycle; a request at edge k gives data and VALID valid after edge k.
- Throughput: one read per port per cycle, back-to-back, with no bubbles.
- RST asserted mid-sweep or mid-read: outputs go to their reset values immediately (asynchronously). The sweep restarts from 0 after release.

## Test plan
- Reset/init: DEPTH=16, INIT_VAL=18'h3FFFF, release RST → READY rises after exactly 16 cycles. Reading all 16 words returns 18'h3FFFF.
- Basic R/W: write 18'h12345 to address 7 on A, read address 7 on B next cycle → B_DOUT=18'h12345 with B_VALID=1 one cycle after the request.
- Bypass: same cycle, A writes 18'h00ABC to address 3 and B reads address 3 → B_DOUT=18'h00ABC.
- Clear: write 18'h1 to address 5, pulse CLEAR → READY low for DEPTH cycles. Requests during the sweep give VALID=0. Afterwards, a read of address 5 returns INIT_VAL.
- Mode/range: with ZERO_IDLE=0, read address 2 (data 18'h55) then idle 3 cycles → A_DOUT stays 18'h55. With ZERO_IDLE=1, A_DOUT is 0 during the idle cycles. Reading address DEPTH (DEPTH<2**AW) → INIT_VAL with VALID=1.
- Reset mid-sweep: drop RST at cycle 5 of init → READY=0 and all outputs 0 at once. After release, the full DEPTH-cycle sweep runs again.
